stream_checker: RTL and testbench

- Synthesizable, parametrised checker for the pixel-stream pipeline (gaussian/octave/difference stages).
- Tracks raster slot position from the source advance strobe and fetches expected pixels from an external 1-cycle ROM.
- Checks DUT data within a tolerance and checks valid timing against active, h-blank and v-blank regions.
- Reports pass/fail, per-class error flags and a failure count, for FPGA self-test and simulation alike.

---
 rtl/stream_pkg.sv | 46 ++++
 rtl/raster_position_counter.sv | 81 ++++++++
 rtl/stream_checker.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_stream_checker.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// ---------------------------------------------------------------------------
// stream_pkg
//
// Shared definitions for the pixel-stream checker and any source-side
// generator that needs to walk the same raster:
//   - state_t      : checker FSM encoding
//   - slot_class_t : what kind of raster slot the current position is
//   - err_class_t  : which error class a detected failure belongs to
//   - default raster geometry (active/total pixels per line, lines per frame)
//   - width_for()  : counter width helper that never returns zero
// ---------------------------------------------------------------------------
package stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_CHECK,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        SLOT_ACTIVE,
        SLOT_HBLANK,
        SLOT_VBLANK
    } slot_class_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_MISSING,
        ERR_MISMATCH,
        ERR_SPURIOUS
    } err_class_t;

    localparam int DEFAULT_LINE_ACTIVE  = 400;
    localparam int DEFAULT_LINE_TOTAL   = 420;
    localparam int DEFAULT_LINES_ACTIVE = 300;
    localparam int DEFAULT_LINES_TOTAL  = 320;

    // Bits needed to hold the values 0..n-1; at least one bit so that
    // degenerate geometries still elaborate.
    function automatic int width_for(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/raster_position_counter.sv
// ---------------------------------------------------------------------------
// raster_position_counter
//
// Walks the raster one slot per 'step' pulse and classifies the slot the
// counter currently points at.  Holding 'step' low freezes the position.
//
// Ports:
//   clock, reset     : system clock, asynchronous active-high reset
//   clear            : synchronous return to slot 0
//   step             : advance to the next slot
//   col, row         : position inside the current frame
//   idx              : linear slot index across all frames
//   slot_class       : ACTIVE / HBLANK / VBLANK of the current position
//   last_slot        : current position is the final slot of the final frame
// ---------------------------------------------------------------------------
module raster_position_counter
    import stream_pkg::*;
#(
    parameter int LINE_ACTIVE  = DEFAULT_LINE_ACTIVE,
    parameter int LINE_TOTAL   = DEFAULT_LINE_TOTAL,
    parameter int LINES_ACTIVE = DEFAULT_LINES_ACTIVE,
    parameter int LINES_TOTAL  = DEFAULT_LINES_TOTAL,
    parameter int NUM_FRAMES   = 1,
    parameter int ADDR_WIDTH   = 18,
    localparam int COL_W       = width_for(LINE_TOTAL),
    localparam int ROW_W       = width_for(LINES_TOTAL)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  step,
    output logic [COL_W-1:0]      col,
    output logic [ROW_W-1:0]      row,
    output logic [ADDR_WIDTH-1:0] idx,
    output slot_class_t           slot_class,
    output logic                  last_slot
);

    localparam int TOTAL_SLOTS = NUM_FRAMES * LINES_TOTAL * LINE_TOTAL;

    localparam logic [COL_W-1:0]      COL_LAST = COL_W'(LINE_TOTAL - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(LINES_TOTAL - 1);
    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(TOTAL_SLOTS - 1);

    // Position registers.  Column wrap bumps the row, row wrap starts the
    // next frame; idx keeps counting across frames and only wraps after the
    // very last slot so a free-running source can loop forever.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
            idx <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
            idx <= '0;
        end else if (step) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // Comparisons are done one bit wider so an active width equal to a
    // power of two cannot alias to zero.
    always_comb begin
        slot_class = SLOT_VBLANK;
        if ({1'b0, col} >= (COL_W + 1)'(LINE_ACTIVE)) begin
            slot_class = SLOT_HBLANK;
        end else if ({1'b0, row} < (ROW_W + 1)'(LINES_ACTIVE)) begin
            slot_class = SLOT_ACTIVE;
        end
    end

    assign last_slot = (idx == IDX_LAST);

endmodule

// File: rtl/stream_checker.sv
// ---------------------------------------------------------------------------
// stream_checker
//
// Self-checking monitor for a pixel-stream pipeline stage.  After 'start' it
// lets DELAY source advances go by (the DUT latency), then checks one DUT
// output per advance against an external 1-cycle-latency expected ROM, and
// finally watches for stray valids for DRAIN_CYCLES clocks.
//
// Ports:
//   clock, reset     : system clock, asynchronous active-high reset
//   start            : one-cycle pulse, only honoured in IDLE
//   advance          : source valid strobe; 0 stalls the raster walk
//   dut_data/valid   : output of the pipeline under test
//   exp_addr         : expected-ROM address (current slot index)
//   exp_data         : ROM data, one cycle after exp_addr
//   busy, done, pass : run status (pass only when clean and not aborted)
//   aborted          : run cut short after MAX_FAILS failures
//   fail_pulse       : one cycle per detected failure
//   err_*            : sticky per-class error flags
//   fail_count       : saturating failure counter
//   first_fail_addr  : slot index of the first failure
// ---------------------------------------------------------------------------
module stream_checker
    import stream_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int SIGNED       = 1,
    parameter int TOLERANCE    = 2,
    parameter int LINE_ACTIVE  = DEFAULT_LINE_ACTIVE,
    parameter int LINE_TOTAL   = DEFAULT_LINE_TOTAL,
    parameter int LINES_ACTIVE = DEFAULT_LINES_ACTIVE,
    parameter int LINES_TOTAL  = DEFAULT_LINES_TOTAL,
    parameter int NUM_FRAMES   = 1,
    parameter int DELAY        = 2545,
    parameter int DRAIN_CYCLES = 100000,
    parameter int CHECK_VBLANK = 0,
    parameter int MAX_FAILS    = 20,
    parameter int ADDR_WIDTH   = 18,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  advance,
    input  logic [DATA_WIDTH-1:0] dut_data,
    input  logic                  dut_valid,
    output logic [ADDR_WIDTH-1:0] exp_addr,
    input  logic [DATA_WIDTH-1:0] exp_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  aborted,
    output logic                  fail_pulse,
    output logic                  err_mismatch,
    output logic                  err_missing,
    output logic                  err_spurious,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr
);

    localparam int COL_W   = width_for(LINE_TOTAL);
    localparam int ROW_W   = width_for(LINES_TOTAL);
    localparam int WARM_W  = width_for(DELAY);
    localparam int DRAIN_W = width_for(DRAIN_CYCLES);

    localparam logic [WARM_W-1:0]    WARM_LAST  = WARM_W'(DELAY - 1);
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] FAIL_LIMIT = CNT_WIDTH'(MAX_FAILS);
    localparam logic [DATA_WIDTH:0]  TOL_EXT    = (DATA_WIDTH + 1)'(TOLERANCE);

    state_t                 state;
    state_t                 state_next;
    logic [WARM_W-1:0]      warm_cnt;
    logic [DRAIN_W-1:0]     drain_cnt;

    // Raster position
    logic [COL_W-1:0]       raster_col_unused;
    logic [ROW_W-1:0]       raster_row_unused;
    logic [ADDR_WIDTH-1:0]  idx;
    slot_class_t            slot_class;
    logic                   last_slot;
    logic                   pos_clear;
    logic                   pos_step;
    logic                   capture;

    // Check pipeline (slot captured on an advance, compared next cycle)
    logic                   pend_valid;
    logic                   pend_dv;
    logic [DATA_WIDTH-1:0]  pend_data;
    slot_class_t            pend_class;
    logic [ADDR_WIDTH-1:0]  pend_idx;
    logic                   pend_last;

    // Comparator / failure bookkeeping
    logic [DATA_WIDTH:0]    dut_ext;
    logic [DATA_WIDTH:0]    exp_ext;
    logic [DATA_WIDTH:0]    diff;
    logic [DATA_WIDTH:0]    abs_diff;
    logic                   out_of_tol;
    err_class_t             fail_cls;
    logic                   fail_now;
    logic [ADDR_WIDTH-1:0]  fail_addr;
    logic [CNT_WIDTH-1:0]   cnt_inc;
    logic [CNT_WIDTH-1:0]   fail_count_next;
    logic                   abort_now;

    // Once the final slot has been captured, further advances must not
    // start another capture; its compare is the last thing CHECK does.
    assign capture   = (state == ST_CHECK) && advance && !(pend_valid && pend_last);

    // The position is not stepped past the final slot, so exp_addr and the
    // idx latched for drain failures stay on the last slot index.
    assign pos_step  = capture && !last_slot;
    assign pos_clear = (state == ST_IDLE) && start;
    assign exp_addr  = idx;

    raster_position_counter #(
        .LINE_ACTIVE  (LINE_ACTIVE),
        .LINE_TOTAL   (LINE_TOTAL),
        .LINES_ACTIVE (LINES_ACTIVE),
        .LINES_TOTAL  (LINES_TOTAL),
        .NUM_FRAMES   (NUM_FRAMES),
        .ADDR_WIDTH   (ADDR_WIDTH)
    ) u_position (
        .clock      (clock),
        .reset      (reset),
        .clear      (pos_clear),
        .step       (pos_step),
        .col        (raster_col_unused),
        .row        (raster_row_unused),
        .idx        (idx),
        .slot_class (slot_class),
        .last_slot  (last_slot)
    );

    // Capture stage: snapshot the DUT output and slot class on each advance
    // so the compare lines up with the ROM data arriving one cycle later,
    // whatever the source does on that following cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_valid <= 1'b0;
            pend_dv    <= 1'b0;
            pend_data  <= '0;
            pend_class <= SLOT_ACTIVE;
            pend_idx   <= '0;
            pend_last  <= 1'b0;
        end else begin
            pend_valid <= capture;
            if (capture) begin
                pend_dv    <= dut_valid;
                pend_data  <= dut_data;
                pend_class <= slot_class;
                pend_idx   <= idx;
                pend_last  <= last_slot;
            end
        end
    end

    // Difference is taken one bit wider than the data so that extremes such
    // as 127 vs -128 give 255 instead of wrapping to a small value.
    always_comb begin
        dut_ext    = (SIGNED != 0) ? {pend_data[DATA_WIDTH-1], pend_data} : {1'b0, pend_data};
        exp_ext    = (SIGNED != 0) ? {exp_data[DATA_WIDTH-1], exp_data} : {1'b0, exp_data};
        diff       = dut_ext - exp_ext;
        abs_diff   = diff[DATA_WIDTH] ? (~diff + 1'b1) : diff;
        out_of_tol = (abs_diff > TOL_EXT);
    end

    // Failure classification: at most one failure per slot (CHECK) or per
    // clock (WARMUP/DRAIN), with missing taking priority over mismatch.
    always_comb begin
        fail_cls  = ERR_NONE;
        fail_addr = idx;
        case (state)
            ST_WARMUP, ST_DRAIN: begin
                if (dut_valid) begin
                    fail_cls = ERR_SPURIOUS;
                end
            end
            ST_CHECK: begin
                fail_addr = pend_idx;
                if (pend_valid) begin
                    case (pend_class)
                        SLOT_ACTIVE: begin
                            if (!pend_dv) begin
                                fail_cls = ERR_MISSING;
                            end else if (out_of_tol) begin
                                fail_cls = ERR_MISMATCH;
                            end
                        end
                        SLOT_HBLANK: begin
                            if (pend_dv) begin
                                fail_cls = ERR_SPURIOUS;
                            end
                        end
                        default: begin
                            if (pend_dv && (CHECK_VBLANK != 0)) begin
                                fail_cls = ERR_SPURIOUS;
                            end
                        end
                    endcase
                end
            end
            default: begin
                fail_cls = ERR_NONE;
            end
        endcase
        fail_now        = (fail_cls != ERR_NONE);
        cnt_inc         = (&fail_count) ? fail_count : fail_count + 1'b1;
        fail_count_next = fail_now ? cnt_inc : fail_count;
        abort_now       = fail_now && (cnt_inc == FAIL_LIMIT);
    end

    // Next-state decode.  Reaching the failure limit overrides every other
    // transition, including the CHECK->DRAIN step on the final slot.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (DELAY == 0) ? ST_CHECK : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (advance && (warm_cnt == WARM_LAST)) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (pend_valid && pend_last) begin
                    state_next = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (abort_now) begin
            state_next = ST_DONE;
        end
    end

    // FSM state, phase counters and all registered result outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            warm_cnt        <= '0;
            drain_cnt       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            aborted         <= 1'b0;
            fail_pulse      <= 1'b0;
            err_mismatch    <= 1'b0;
            err_missing     <= 1'b0;
            err_spurious    <= 1'b0;
            fail_count      <= '0;
            first_fail_addr <= '0;
        end else begin
            state      <= state_next;
            busy       <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            done       <= (state_next == ST_DONE);
            pass       <= (state_next == ST_DONE) && (fail_count_next == '0)
                          && !aborted && !abort_now;
            fail_pulse <= fail_now;

            if (state == ST_WARMUP) begin
                if (advance) begin
                    warm_cnt <= warm_cnt + 1'b1;
                end
            end else begin
                warm_cnt <= '0;
            end

            drain_cnt <= (state == ST_DRAIN) ? drain_cnt + 1'b1 : '0;

            if (fail_now) begin
                fail_count <= cnt_inc;
                if (fail_count == '0) begin
                    first_fail_addr <= fail_addr;
                end
                case (fail_cls)
                    ERR_MISSING:  err_missing  <= 1'b1;
                    ERR_MISMATCH: err_mismatch <= 1'b1;
                    ERR_SPURIOUS: err_spurious <= 1'b1;
                    default:      err_spurious <= err_spurious;
                endcase
            end

            if (abort_now) begin
                aborted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stream_checker.sv
// ---------------------------------------------------------------------------
// tb_stream_checker
//
// Directed scenarios on a tiny raster (6 slots x 4 lines, 4x3 active,
// 24 slots total) with DELAY=5, DRAIN_CYCLES=8, MAX_FAILS=5, signed 8-bit
// data and TOLERANCE=2.  The expected ROM is modelled in the bench with one
// clock of read latency.
// ---------------------------------------------------------------------------
module tb_stream_checker;

    localparam int DW     = 8;
    localparam int LA     = 4;
    localparam int LT     = 6;
    localparam int RA     = 3;
    localparam int RT     = 4;
    localparam int DLY    = 5;
    localparam int DRN    = 8;
    localparam int NSLOTS = LT * RT;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          advance;
    logic [DW-1:0] dut_data;
    logic          dut_valid;
    logic [7:0]    exp_addr;
    logic [DW-1:0] exp_data = '0;
    logic          busy;
    logic          done;
    logic          pass;
    logic          aborted;
    logic          fail_pulse;
    logic          err_mismatch;
    logic          err_missing;
    logic          err_spurious;
    logic [7:0]    fail_count;
    logic [7:0]    first_fail_addr;

    logic [DW-1:0] rom [NSLOTS];
    logic [DW-1:0] slot_data [NSLOTS];
    logic          slot_valid [NSLOTS];

    int n_compared   = 0;
    int n_mismatched = 0;
    int pulse_count  = 0;
    int pulse_base;
    logic [7:0] stall_first_addr;
    logic [7:0] stall_last_addr;
    logic       stall_busy;
    logic [6:0] status;

    always #5 clock = ~clock;

    stream_checker #(
        .DATA_WIDTH   (DW),
        .SIGNED       (1),
        .TOLERANCE    (2),
        .LINE_ACTIVE  (LA),
        .LINE_TOTAL   (LT),
        .LINES_ACTIVE (RA),
        .LINES_TOTAL  (RT),
        .NUM_FRAMES   (1),
        .DELAY        (DLY),
        .DRAIN_CYCLES (DRN),
        .CHECK_VBLANK (0),
        .MAX_FAILS    (5),
        .ADDR_WIDTH   (8),
        .CNT_WIDTH    (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .advance         (advance),
        .dut_data        (dut_data),
        .dut_valid       (dut_valid),
        .exp_addr        (exp_addr),
        .exp_data        (exp_data),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .aborted         (aborted),
        .fail_pulse      (fail_pulse),
        .err_mismatch    (err_mismatch),
        .err_missing     (err_missing),
        .err_spurious    (err_spurious),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr)
    );

    // Expected-pixel ROM with one clock of read latency
    always @(posedge clock) begin
        exp_data <= (exp_addr < 8'(NSLOTS)) ? rom[exp_addr[4:0]] : 8'h00;
    end

    // Count fail pulses, sampled on the falling edge
    always @(negedge clock) begin
        if (fail_pulse === 1'b1) begin
            pulse_count <= pulse_count + 1;
        end
    end

    assign status = {done, pass, aborted, busy, err_mismatch, err_missing, err_spurious};

    function automatic bit is_active(input int k);
        return ((k % LT) < LA) && ((k / LT) < RA);
    endfunction

    task automatic prepare_ideal();
        for (int k = 0; k < NSLOTS; k++) begin
            slot_valid[k] = is_active(k);
            slot_data[k]  = is_active(k) ? rom[k] : 8'h00;
        end
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        start     = 1'b0;
        advance   = 1'b0;
        dut_valid = 1'b0;
        dut_data  = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // Drives one run: start pulse, DELAY warm-up advances, n_slots stream
    // slots (optionally with a stall before slot stall_at), then waits a
    // bounded time for done while optionally injecting one drain valid.
    task automatic apply_stimulus(input int warm_spur, input int stall_at,
                                  input int stall_len, input int drain_spur,
                                  input int n_slots);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        for (int w = 0; w < DLY; w++) begin
            advance   = 1'b1;
            dut_valid = (w == warm_spur);
            dut_data  = '0;
            @(posedge clock);
            #1;
        end
        for (int k = 0; k < n_slots; k++) begin
            if (k == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    advance   = 1'b0;
                    dut_valid = 1'b0;
                    @(posedge clock);
                    #1;
                    if (s == 0) stall_first_addr = exp_addr;
                    if (s == stall_len / 2) stall_busy = busy;
                    stall_last_addr = exp_addr;
                end
            end
            advance   = 1'b1;
            dut_valid = slot_valid[k];
            dut_data  = slot_data[k];
            @(posedge clock);
            #1;
        end
        advance   = 1'b0;
        dut_valid = 1'b0;
        dut_data  = '0;
        if (n_slots == NSLOTS) begin
            for (int c = 0; c < 60 && done !== 1'b1; c++) begin
                dut_valid = (c == drain_spur);
                @(posedge clock);
                #1;
            end
            dut_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_compared++;
        if ({status, fail_pulse} !== 8'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_status: got %b want 00000000", {status, fail_pulse});
        end
        n_compared++;
        if (fail_count !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_count: got %0d want 0", fail_count);
        end
        n_compared++;
        if ({exp_addr, first_fail_addr} !== 16'd0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_addr: got %h/%h want 00/00", exp_addr, first_fail_addr);
        end
    endtask

    task automatic test_ideal();
        apply_reset();
        prepare_ideal();
        pulse_base = pulse_count;
        apply_stimulus(-1, -1, 0, -1, NSLOTS);
        n_compared++;
        if (status !== 7'b1100000) begin
            n_mismatched++;
            $display("[TB] FAIL ideal_status: got %b want 1100000", status);
        end
        n_compared++;
        if (fail_count !== 8'd0 || pulse_count != pulse_base) begin
            n_mismatched++;
            $display("[TB] FAIL ideal_count: got %0d pulses %0d want 0/0", fail_count, pulse_count - pulse_base);
        end
        // start must be ignored while DONE
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        n_compared++;
        if (status !== 7'b1100000) begin
            n_mismatched++;
            $display("[TB] FAIL done_hold: got %b want 1100000", status);
        end
    endtask

    task automatic test_tolerance();
        apply_reset();
        prepare_ideal();
        slot_data[7] = rom[7] + 8'd3;
        pulse_base = pulse_count;
        apply_stimulus(-1, -1, 0, -1, NSLOTS);
        n_compared++;
        if (status !== 7'b1000100 || fail_count !== 8'd1) begin
            n_mismatched++;
            $display("[TB] FAIL tol_plus3: got %b cnt %0d want 1000100 cnt 1", status, fail_count);
        end
        n_compared++;
        if (first_fail_addr !== 8'd7 || pulse_count - pulse_base != 1) begin
            n_mismatched++;
            $display("[TB] FAIL tol_plus3_addr: got %0d pulses %0d want 7/1", first_fail_addr, pulse_count - pulse_base);
        end

        apply_reset();
        prepare_ideal();
        slot_data[7]  = rom[7] + 8'd2;
        slot_data[14] = rom[14] - 8'd2;
        apply_stimulus(-1, -1, 0, -1, NSLOTS);
        n_compared++;
        if (status !== 7'b1100000 || fail_count !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL tol_edge2: got %b cnt %0d want 1100000 cnt 0", status, fail_count);
        end

        apply_reset();
        prepare_ideal();
        slot_data[14] = rom[14] - 8'd3;
        apply_stimulus(-1, -1, 0, -1, NSLOTS);
        n_compared++;
        if (status !== 7'b1000100 || fail_count !== 8'd1 || first_fail_addr !== 8'd14) begin
            n_mismatched++;
            $display("[TB] FAIL tol_minus3: got %b cnt %0d addr %0d want 1000100 cnt 1 addr 14", status, fail_count, first_fail_addr);
        end
    endtask

    task automatic test_valid_classes();
        apply_reset();
        prepare_ideal();
        slot_valid[2]  = 1'b0;
        slot_valid[10] = 1'b1;
        slot_valid[19] = 1'b1;
        apply_stimulus(-1, -1, 0, -1, NSLOTS);
        n_compared++;
        if (status !== 7'b1000011 || fail_count !== 8'd2) begin
            n_mismatched++;
            $display("[TB] FAIL classes: got %b cnt %0d want 1000011 cnt 2", status, fail_count);
        end
        n_compared++;
        if (first_fail_addr !== 8'd2) begin
            n_mismatched++;
            $display("[TB] FAIL classes_addr: got %0d want 2", first_fail_addr);
        end
    endtask

    task automatic test_stall();
        apply_reset();
        prepare_ideal();
        apply_stimulus(-1, 13, 30, -1, NSLOTS);
        n_compared++;
        if (stall_first_addr !== 8'd13 || stall_last_addr !== 8'd13 || stall_busy !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL stall_addr: got %0d..%0d busy %b want 13..13 busy 1", stall_first_addr, stall_last_addr, stall_busy);
        end
        n_compared++;
        if (status !== 7'b1100000 || fail_count !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL stall_status: got %b cnt %0d want 1100000 cnt 0", status, fail_count);
        end
    endtask

    task automatic test_signed_extreme();
        apply_reset();
        prepare_ideal();
        slot_data[8] = 8'h80;
        apply_stimulus(-1, -1, 0, -1, NSLOTS);
        n_compared++;
        if (status !== 7'b1000100 || fail_count !== 8'd1 || first_fail_addr !== 8'd8) begin
            n_mismatched++;
            $display("[TB] FAIL signed_extreme: got %b cnt %0d addr %0d want 1000100 cnt 1 addr 8", status, fail_count, first_fail_addr);
        end
    endtask

    task automatic test_abort();
        apply_reset();
        prepare_ideal();
        slot_data[0] = rom[0] + 8'd10;
        slot_data[1] = rom[1] + 8'd10;
        slot_data[2] = rom[2] + 8'd10;
        slot_data[3] = rom[3] + 8'd10;
        slot_data[6] = rom[6] + 8'd10;
        slot_data[7] = rom[7] + 8'd10;
        apply_stimulus(0, -1, 0, -1, NSLOTS);
        n_compared++;
        if (status !== 7'b1010101 || fail_count !== 8'd5) begin
            n_mismatched++;
            $display("[TB] FAIL abort: got %b cnt %0d want 1010101 cnt 5", status, fail_count);
        end
        n_compared++;
        if (first_fail_addr !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL abort_addr: got %0d want 0", first_fail_addr);
        end
    endtask

    task automatic test_drain();
        apply_reset();
        prepare_ideal();
        apply_stimulus(-1, -1, 0, 2, NSLOTS);
        n_compared++;
        if (status !== 7'b1000001 || fail_count !== 8'd1 || first_fail_addr !== 8'd23) begin
            n_mismatched++;
            $display("[TB] FAIL drain: got %b cnt %0d addr %0d want 1000001 cnt 1 addr 23", status, fail_count, first_fail_addr);
        end
    endtask

    task automatic test_last_slot_abort();
        apply_reset();
        prepare_ideal();
        for (int k = 0; k < 4; k++) begin
            slot_data[k] = rom[k] + 8'd10;
        end
        slot_valid[23] = 1'b1;
        apply_stimulus(-1, -1, 0, -1, NSLOTS);
        n_compared++;
        if (status !== 7'b1010101 || fail_count !== 8'd5) begin
            n_mismatched++;
            $display("[TB] FAIL last_slot_abort: got %b cnt %0d want 1010101 cnt 5", status, fail_count);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        prepare_ideal();
        slot_valid[2] = 1'b0;
        apply_stimulus(-1, -1, 0, -1, 8);
        n_compared++;
        if (busy !== 1'b1 || fail_count !== 8'd1) begin
            n_mismatched++;
            $display("[TB] FAIL mid_before_reset: got busy %b cnt %0d want busy 1 cnt 1", busy, fail_count);
        end
        reset = 1'b1;
        #2;
        n_compared++;
        if (status !== 7'b0 || fail_count !== 8'd0 || exp_addr !== 8'd0 || first_fail_addr !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_reset: got %b cnt %0d addr %0d/%0d want 0000000 cnt 0 addr 0/0", status, fail_count, exp_addr, first_fail_addr);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        prepare_ideal();
        apply_stimulus(-1, -1, 0, -1, NSLOTS);
        n_compared++;
        if (status !== 7'b1100000 || fail_count !== 8'd0) begin
            n_mismatched++;
            $display("[TB] FAIL mid_rerun: got %b cnt %0d want 1100000 cnt 0", status, fail_count);
        end
    endtask

    initial begin
        for (int k = 0; k < NSLOTS; k++) begin
            rom[k] = 8'(k * 9 + 20);
        end
        rom[8] = 8'd127;
        test_reset();
        test_ideal();
        test_tolerance();
        test_valid_classes();
        test_stall();
        test_signed_extreme();
        test_abort();
        test_drain();
        test_last_slot_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
